message_outqueue: RTL and testbench

Transmit-side outbound queue for one PE neighbour link (north/east/west/south). It accepts field-level message requests from PE control logic and packs them into the standard MSG_WIDTH word. It buffers them in a small FIFO and presents them on the outqueue value/valid/ready handshake consumed by the neighbour's mailbox. One instance per direction; it is the producer end of the mailbox link.

---
 rtl/message_outqueue.sv | 102 ++++++++++
 tb/tb_message_outqueue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/message_outqueue.sv
// Outbound message queue for one PE neighbour link: packs field-level requests into a
// message word, discards requests with no hop budget left, and presents a show-ahead FIFO head.
module message_outqueue #(
    parameter int CORDINATE_WIDTH = 4,
    parameter int TIMESTAMP_WIDTH = 6,
    parameter int COST_WIDTH      = 6,
    parameter int MAX_HOP_WIDTH   = 4,
    parameter int MSG_TYPE_WIDTH  = 3,
    parameter int DEPTH           = 4,
    localparam int MSG_WIDTH = 6*CORDINATE_WIDTH + TIMESTAMP_WIDTH + COST_WIDTH
                             + MAX_HOP_WIDTH + MSG_TYPE_WIDTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [CORDINATE_WIDTH-1:0] enq_receiver_row,
    input  logic [CORDINATE_WIDTH-1:0] enq_receiver_col,
    input  logic [CORDINATE_WIDTH-1:0] enq_source_row,
    input  logic [CORDINATE_WIDTH-1:0] enq_source_col,
    input  logic [CORDINATE_WIDTH-1:0] enq_broker_row,
    input  logic [CORDINATE_WIDTH-1:0] enq_broker_col,
    input  logic [TIMESTAMP_WIDTH-1:0] enq_timestamp,
    input  logic [COST_WIDTH-1:0]      enq_cost,
    input  logic [MAX_HOP_WIDTH-1:0]   enq_max_hops,
    input  logic [MSG_TYPE_WIDTH-1:0]  enq_msg_type,
    output logic [MSG_WIDTH-1:0]       outqueue_value_out,
    output logic                       outqueue_valid_out,
    input  logic                       outqueue_ready_in,
    output logic [7:0]                 drop_count,
    output logic [CNT_W-1:0]           occupancy
);

    logic [MSG_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [7:0]           drop_q, drop_d;

    logic                 enq_fire, wr_fire, drop_fire, deq_fire;
    logic [MSG_WIDTH-1:0] packed_word;

    assign enq_ready          = (count_q != CNT_W'(DEPTH));
    assign outqueue_valid_out = (count_q != '0);
    assign occupancy          = count_q;
    assign drop_count         = drop_q;

    // Flush wins over any concurrent transfer, so it also suppresses drop counting.
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign wr_fire   = enq_fire && (enq_max_hops != '0);
    assign drop_fire = enq_fire && (enq_max_hops == '0);
    assign deq_fire  = outqueue_valid_out && outqueue_ready_in && !flush;

    assign packed_word = {enq_receiver_row, enq_receiver_col,
                          enq_source_row,   enq_source_col,
                          enq_broker_row,   enq_broker_col,
                          enq_timestamp,    enq_cost,
                          enq_max_hops - MAX_HOP_WIDTH'(1), enq_msg_type};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_fire && !deq_fire)      count_d = count_q + CNT_W'(1);
            else if (!wr_fire && deq_fire) count_d = count_q - CNT_W'(1);
            if (drop_fire && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is deliberately left out of reset; the output mux hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= packed_word;
    end

    assign outqueue_value_out = outqueue_valid_out ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_message_outqueue.sv
// Directed bench for message_outqueue: packing, backpressure, wrap, hop drop, flush, async reset.
module tb_message_outqueue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [3:0]  rr = '0, rc = '0, sr = '0, sc = '0, br = '0, bc = '0;
    logic [5:0]  ts = '0, cost = '0;
    logic [3:0]  hops = '0;
    logic [2:0]  mtype = '0;
    logic [42:0] value_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [7:0]  drop_count;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    message_outqueue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_receiver_row(rr), .enq_receiver_col(rc),
        .enq_source_row(sr), .enq_source_col(sc),
        .enq_broker_row(br), .enq_broker_col(bc),
        .enq_timestamp(ts), .enq_cost(cost),
        .enq_max_hops(hops), .enq_msg_type(mtype),
        .outqueue_value_out(value_out), .outqueue_valid_out(valid_out),
        .outqueue_ready_in(ready_in),
        .drop_count(drop_count), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Message k is driven with hop budget 3, so the stored word must carry 2.
    task automatic drive_msg(input int k);
        logic [7:0] kb;
        kb    = 8'(k);
        rr    = kb[3:0];
        rc    = ~kb[3:0];
        sr    = kb[3:0] + 4'd1;
        sc    = kb[3:0] + 4'd2;
        br    = 4'd5;
        bc    = 4'd10;
        ts    = kb[5:0];
        cost  = 6'h20 | kb[5:0];
        hops  = 4'd3;
        mtype = kb[2:0];
    endtask

    function automatic logic [42:0] exp_msg(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {kb[3:0], ~kb[3:0], kb[3:0] + 4'd1, kb[3:0] + 4'd2, 4'd5, 4'd10,
                kb[5:0], 6'h20 | kb[5:0], 4'd2, kb[2:0]};
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_valid", 64'(valid_out), 64'd0);
        check_eq("rst_value", 64'(value_out), 64'd0);
        check_eq("rst_occ", 64'(occupancy), 64'd0);
        check_eq("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b1;
        #1;
        check_eq("rst_enq_ready", 64'(enq_ready), 64'd1);

        // Single packet: hops 15 in, 14 stored
        rr = 4'd4; rc = 4'd2; sr = 4'd4; sc = 4'd3; br = 4'd4; bc = 4'd3;
        ts = 6'd30; cost = 6'd59; hops = 4'd15; mtype = 3'd1;
        ready_in = 1'b1; enq_valid = 1'b1;
        tick();
        enq_valid = 1'b0;
        check_eq("single_valid", 64'(valid_out), 64'd1);
        check_eq("single_value", 64'(value_out), 64'h2121A1BDDF1);
        check_eq("single_hops", 64'(value_out[6:3]), 64'd14);
        tick();
        check_eq("single_valid_drop", 64'(valid_out), 64'd0);

        // Backpressure fill
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_msg(i + 1);
            enq_valid = 1'b1;
            check_eq($sformatf("bp_enq_ready_%0d", i), 64'(enq_ready), (i < 4) ? 64'd1 : 64'd0);
            tick();
            check_eq($sformatf("bp_head_%0d", i), 64'(value_out), 64'(exp_msg(1)));
        end
        enq_valid = 1'b0;
        check_eq("bp_occ_full", 64'(occupancy), 64'd4);
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain_value_%0d", i), 64'(value_out), 64'(exp_msg(i + 1)));
            tick();
        end
        check_eq("drain_empty", 64'(valid_out), 64'd0);

        // Wrap-around streaming
        for (int i = 0; i < 10; i++) begin
            drive_msg(i);
            enq_valid = 1'b1;
            tick();
            check_eq($sformatf("wrap_value_%0d", i), 64'(value_out), 64'(exp_msg(i)));
            check_eq($sformatf("wrap_occ_%0d", i), 64'(occupancy), 64'd1);
        end
        enq_valid = 1'b0;
        tick();
        check_eq("wrap_empty", 64'(valid_out), 64'd0);

        // Hop drop and saturation
        drive_msg(7);
        hops = 4'd0;
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("drop_valid_%0d", i), 64'(valid_out), 64'd0);
        end
        check_eq("drop_count_3", 64'(drop_count), 64'd3);
        for (int i = 0; i < 300; i++) tick();
        enq_valid = 1'b0;
        check_eq("drop_count_sat", 64'(drop_count), 64'd255);
        check_eq("drop_occ", 64'(occupancy), 64'd0);

        // Flush with concurrent enqueue and dequeue
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_msg(i + 20);
            enq_valid = 1'b1;
            tick();
        end
        check_eq("flush_pre_occ", 64'(occupancy), 64'd3);
        drive_msg(30);
        flush = 1'b1; ready_in = 1'b1; enq_valid = 1'b1;
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        check_eq("flush_occ", 64'(occupancy), 64'd0);
        check_eq("flush_valid", 64'(valid_out), 64'd0);
        check_eq("flush_drop", 64'(drop_count), 64'd255);

        // Asynchronous reset mid-stream
        ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_msg(i + 40);
            enq_valid = 1'b1;
            tick();
        end
        enq_valid = 1'b0;
        check_eq("areset_pre_occ", 64'(occupancy), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_eq("areset_valid", 64'(valid_out), 64'd0);
        check_eq("areset_value", 64'(value_out), 64'd0);
        check_eq("areset_occ", 64'(occupancy), 64'd0);
        check_eq("areset_drop", 64'(drop_count), 64'd0);
        tick();
        reset = 1'b1;
        drive_msg(50);
        enq_valid = 1'b1;
        ready_in = 1'b1;
        tick();
        enq_valid = 1'b0;
        check_eq("post_reset_valid", 64'(valid_out), 64'd1);
        check_eq("post_reset_value", 64'(value_out), 64'(exp_msg(50)));
        tick();
        check_eq("post_reset_empty", 64'(valid_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
